// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares one register-file write port between the pipeline
// (fixed priority, zero latency) and a small queue of mul/div results.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_Rd,
    input  logic [31:0] MEM_WB_write_data,
    input  logic        MD_valid,
    input  logic [4:0]  MD_Rd,
    input  logic [31:0] MD_data,
    output logic        MD_ready,
    output logic        RF_RegWrite,
    output logic [4:0]  RF_Rd,
    output logic [31:0] RF_write_data,
    output logic        Starve_stall
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;
    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic pipe_active, queue_empty, head_valid, push, pop;

    assign pipe_active = MEM_WB_RegWrite && (MEM_WB_Rd != 5'd0);
    assign queue_empty = (count_q == '0);
    assign head_valid  = !queue_empty && valid_q[head_q];
    assign pop         = !queue_empty && !pipe_active;
    assign MD_ready    = (count_q < CW'(DEPTH));
    assign push        = MD_valid && MD_ready && (MD_Rd != 5'd0);
    assign Starve_stall = stall_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        RF_RegWrite   = 1'b0;
        RF_Rd         = 5'd0;
        RF_write_data = 32'd0;
        if (pipe_active) begin
            RF_RegWrite   = 1'b1;
            RF_Rd         = MEM_WB_Rd;
            RF_write_data = MEM_WB_write_data;
        end else if (pop && head_valid) begin
            RF_RegWrite   = 1'b1;
            RF_Rd         = rd_mem[head_q];
            RF_write_data = data_mem[head_q];
        end
    end

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        // A pipeline write to the same register makes any older queued result stale.
        if (pipe_active) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_mem[i] == MEM_WB_Rd) valid_d[i] = 1'b0;
            end
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            valid_d[tail_q] = !(pipe_active && (MD_Rd == MEM_WB_Rd));
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (pop || queue_empty) begin
            starve_d = '0;
        end else if (head_valid && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = head_valid && !pop && (starve_q >= SW'(STARVE_LIMIT - 1));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // NOTE: payload storage is not reset; the valid bits and count alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_q]   <= MD_Rd;
            data_mem[tail_q] <= MD_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_Rd;
    logic [31:0] MEM_WB_write_data;
    logic        MD_valid;
    logic [4:0]  MD_Rd;
    logic [31:0] MD_data;
    logic        MD_ready;
    logic        RF_RegWrite;
    logic [4:0]  RF_Rd;
    logic [31:0] RF_write_data;
    logic        Starve_stall;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_Rd        (MEM_WB_Rd),
        .MEM_WB_write_data(MEM_WB_write_data),
        .MD_valid         (MD_valid),
        .MD_Rd            (MD_Rd),
        .MD_data          (MD_data),
        .MD_ready         (MD_ready),
        .RF_RegWrite      (RF_RegWrite),
        .RF_Rd            (RF_Rd),
        .RF_write_data    (RF_write_data),
        .Starve_stall     (Starve_stall)
    );

    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit [31:0] d;
    } entry_t;

    entry_t q[$];
    int     starve = 0;
    bit     stall  = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit rw, input bit [4:0] rrd, input bit [31:0] rdat,
                         input bit mv, input bit [4:0] mrd, input bit [31:0] mdat);
        reset             = rst;
        MEM_WB_RegWrite   = rw;
        MEM_WB_Rd         = rrd;
        MEM_WB_write_data = rdat;
        MD_valid          = mv;
        MD_Rd             = mrd;
        MD_data           = mdat;
        #1;
    endtask

    task automatic compare_all();
        bit        pa;
        bit        ew;
        bit [4:0]  erd;
        bit [31:0] ed;
        pa  = MEM_WB_RegWrite && (MEM_WB_Rd != 5'd0);
        ew  = 1'b0;
        erd = 5'd0;
        ed  = 32'd0;
        if (pa) begin
            ew = 1'b1; erd = MEM_WB_Rd; ed = MEM_WB_write_data;
        end else if (q.size() > 0 && q[0].v) begin
            ew = 1'b1; erd = q[0].rd; ed = q[0].d;
        end
        check("md_ready", MD_ready, (q.size() < DEPTH));
        check("rf_we", RF_RegWrite, ew);
        check("rf_rd", RF_Rd, erd);
        check("rf_data", RF_write_data, ed);
        check("starve_stall", Starve_stall, stall);
    endtask

    // Advance the model by the rules of one clock edge, then let the DUT take the same edge.
    task automatic tick();
        int n;
        bit pa, ready, hv, pop;
        if (reset) begin
            q.delete();
            starve = 0;
            stall  = 1'b0;
        end else begin
            n     = q.size();
            pa    = MEM_WB_RegWrite && (MEM_WB_Rd != 5'd0);
            ready = (n < DEPTH);
            hv    = (n > 0) && q[0].v;
            pop   = (n > 0) && !pa;
            stall = hv && !pop && (starve >= LIMIT - 1);
            if (pop || n == 0) starve = 0;
            else if (hv && starve < LIMIT) starve++;
            if (pa) foreach (q[i]) if (q[i].rd == MEM_WB_Rd) q[i].v = 1'b0;
            if (pop) void'(q.pop_front());
            if (MD_valid && ready && MD_Rd != 5'd0)
                q.push_back('{v: !(pa && MD_Rd == MEM_WB_Rd), rd: MD_Rd, d: MD_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit rst, input bit rw, input bit [4:0] rrd, input bit [31:0] rdat,
                        input bit mv, input bit [4:0] mrd, input bit [31:0] mdat);
        drive(rst, rw, rrd, rdat, mv, mrd, mdat);
        compare_all();
        tick();
    endtask

    initial begin
        int p;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        compare_all();
        tick();

        // Reset state, then a pipeline write on an idle queue wins immediately.
        drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        compare_all();
        check("rst_ready", MD_ready, 1);
        check("rst_stall", Starve_stall, 0);
        check("pipe_we", RF_RegWrite, 1);
        check("pipe_rd", RF_Rd, 5);
        check("pipe_data", RF_write_data, 32'hDEADBEEF);
        tick();

        // Single MD result writes one cycle later.
        step(0, 0, 0, 0, 1, 7, 32'h12);
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("md_we", RF_RegWrite, 1);
        check("md_rd", RF_Rd, 7);
        check("md_data", RF_write_data, 32'h12);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("md_drained", MD_ready, 1);
        check("md_idle_we", RF_RegWrite, 0);
        tick();

        // Starvation: two results blocked by back-to-back pipeline writes.
        step(0, 1, 1, 32'h1111, 1, 10, 32'hA);
        drive(0, 1, 1, 32'h1112, 1, 11, 32'hB);
        compare_all();
        check("ready_2nd", MD_ready, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 32'h2000 + i, 0, 0, 0);
            compare_all();
            check("full_ready", MD_ready, 0);
            check("pre_stall", Starve_stall, 0);
            tick();
        end
        drive(0, 1, 1, 32'h3000, 0, 0, 0);
        compare_all();
        check("stall_set", Starve_stall, 1);
        check("stall_pipe_wins", RF_Rd, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("bubble_rd", RF_Rd, 10);
        check("bubble_data", RF_write_data, 32'hA);
        tick();
        drive(0, 1, 1, 32'h3001, 0, 0, 0);
        compare_all();
        check("stall_clear", Starve_stall, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("second_rd", RF_Rd, 11);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);

        // WAW kill of a queued entry.
        step(0, 0, 0, 0, 1, 9, 32'h99);
        drive(0, 1, 9, 32'h9999, 0, 0, 0);
        compare_all();
        check("kill_pipe_data", RF_write_data, 32'h9999);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("killed_pop_we", RF_RegWrite, 0);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset with a full, starving queue.
        step(0, 1, 1, 32'h1, 1, 12, 32'hC);
        step(0, 1, 1, 32'h2, 1, 13, 32'hD);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h3, 0, 0, 0);
        drive(0, 1, 1, 32'h4, 0, 0, 0);
        compare_all();
        check("pre_rst_stall", Starve_stall, 1);
        tick();
        step(1, 0, 0, 0, 1, 14, 32'hE);
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("post_rst_ready", MD_ready, 1);
        check("post_rst_stall", Starve_stall, 0);
        check("post_rst_we", RF_RegWrite, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            compare_all();
            check("post_rst_quiet", RF_RegWrite, 0);
            tick();
        end

        // Pipeline write to r0 is inactive; the queue head takes the port.
        step(0, 0, 0, 0, 1, 3, 32'h33);
        drive(0, 1, 0, 32'hBAD, 0, 0, 0);
        compare_all();
        check("rd0_head_rd", RF_Rd, 3);
        check("rd0_head_data", RF_write_data, 32'h33);
        tick();

        // Same-cycle push killed by a matching pipeline write; MD_Rd=0 discarded.
        step(0, 1, 4, 32'h4444, 1, 4, 32'h44);
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("push_killed_we", RF_RegWrite, 0);
        tick();
        step(0, 0, 0, 0, 1, 0, 32'h55);
        drive(0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("rd0_discard_we", RF_RegWrite, 0);
        check("rd0_discard_ready", MD_ready, 1);
        tick();

        // Random traffic, alternating light and heavy pipeline load.
        for (int i = 0; i < 3000; i++) begin
            p = ((i / 400) % 2 == 1) ? 90 : 40;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < p),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 ($urandom_range(0, 99) < 50),
                 5'($urandom_range(0, 7)),
                 $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: number of entries in the mul/div result queue (power of two, minimum 2).
REQ-002 Parameter STARVE_LIMIT, default 4: number of cycles a valid queue head may wait before a stall is requested.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port MEM_WB_RegWrite, input, 1: pipeline writeback request.
REQ-006 Port MEM_WB_Rd, input, 5: pipeline destination register.
REQ-007 Port MEM_WB_write_data, input, 32: pipeline writeback data.
REQ-008 Port MD_valid, input, 1: mul/div unit presents a result.
REQ-009 Port MD_Rd, input, 5: mul/div destination register.
REQ-010 Port MD_data, input, 32: mul/div result.
REQ-011 Port MD_ready, output, 1: queue can accept a result this cycle.
REQ-012 Port RF_RegWrite, output, 1: register-file write enable.
REQ-013 Port RF_Rd, output, 5: register-file write address.
REQ-014 Port RF_write_data, output, 32: register-file write data.
REQ-015 Port Starve_stall, output, 1: registered request to the hazard unit to insert a writeback bubble.

Function
REQ-016 A pipeline write SHALL be active only when MEM_WB_RegWrite=1 and MEM_WB_Rd!=0; an inactive pipeline write SHALL not use the port.
REQ-017 The arbiter SHALL contain a circular queue of DEPTH entries, each holding a valid bit, Rd and data, with head/tail pointers and an occupancy count.
REQ-018 MD_ready SHALL equal (count<DEPTH), derived from registered state only.
REQ-019 A push SHALL occur when MD_valid=1 and MD_ready=1 and MD_Rd!=0; a result with MD_Rd=0 SHALL be accepted and discarded.
REQ-020 A pushed entry SHALL become visible at the head no earlier than the next cycle; there is no bypass from MD inputs to the RF outputs.
REQ-021 Port priority SHALL be fixed: an active pipeline write drives RF_* combinationally in the same cycle (zero latency).
REQ-022 When no pipeline write is active and the queue head is valid, the head SHALL drive RF_* and SHALL be popped at the clock edge.
REQ-023 When no pipeline write is active and the queue head is invalid (killed), the head SHALL be popped with RF_RegWrite=0.
REQ-024 When neither source writes, RF_RegWrite SHALL be 0 and RF_Rd/RF_write_data SHALL be 0.
REQ-025 WAW kill: an active pipeline write SHALL clear the valid bit of every queued entry whose Rd equals MEM_WB_Rd.
REQ-026 A same-cycle push whose MD_Rd equals an active MEM_WB_Rd SHALL be accepted with its valid bit cleared.
REQ-027 When the queue is full, a push and a pop SHALL never coincide, because MD_ready=0.
REQ-028 When the queue is not full, a simultaneous push and pop SHALL leave count unchanged.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 The starve counter SHALL increment while the head is valid and not popped, saturating at STARVE_LIMIT.
REQ-031 The starve counter SHALL clear on any pop or when the queue is empty.
REQ-032 Starve_stall SHALL be registered and set to 1 in the cycle after the counter reaches STARVE_LIMIT-1 with the head still unpopped.
REQ-033 Starve_stall SHALL clear in the cycle after the head pops.
REQ-034 Pipeline writes arriving while Starve_stall=1 SHALL still win the port.

Reset
REQ-035 On reset=1 at a clock edge, the following SHALL be cleared: count, pointers, all valid bits, the starve counter and Starve_stall.
REQ-036 Reset SHALL discard queued entries mid-operation; the first cycle after reset SHALL show MD_ready=1, Starve_stall=0 and RF_RegWrite driven only by the pipeline inputs.
REQ-037 Reset SHALL take priority over a same-cycle push or pop.

Verification
REQ-038 Idle queue with pipeline write (Rd=5, data=0xDEADBEEF) -> RF_RegWrite=1, RF_Rd=5, RF_write_data=0xDEADBEEF in the same cycle.
REQ-039 MD push (Rd=7, data=0x12) with no pipeline write -> RF writes Rd=7, data=0x12 exactly one cycle later; count returns to 0.
REQ-040 Two MD pushes with pipeline writes every cycle -> MD_ready=0 after the second push; Starve_stall=1 after 4 blocked cycles; after one pipeline bubble, entry 1 writes and Starve_stall clears the next cycle.
REQ-041 Queued entry Rd=9, then pipeline write Rd=9 -> the entry is killed and later popped with RF_RegWrite=0; register 9 holds the pipeline value.
REQ-042 Reset asserted with a full queue and Starve_stall=1 -> next cycle count=0, MD_ready=1, Starve_stall=0, and no MD write ever appears.
REQ-043 Pipeline write with Rd=0 and a valid queue head -> the head wins the port (REQ-016).
